// File: rtl/traffic_light_actuated.sv
// Two-approach actuated traffic light with latched side/pedestrian demand,
// walk lamp, flashing mode and a tick prescaler. All outputs registered.
module traffic_light_actuated #(
  parameter int unsigned TICK_DIV     = 27000000,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned T_ALLRED     = 1,
  parameter int unsigned T_GREEN_MIN  = 10,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_SIDE_GREEN = 8,
  parameter int unsigned T_WALK       = 5
) (
  input  logic             clk_27M,
  input  logic             reset,
  input  logic             stopline,
  input  logic             ped_req,
  input  logic             flash_en,
  output logic [1:0]       R,
  output logic [1:0]       Y,
  output logic [1:0]       G,
  output logic             W,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] countdown
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  localparam logic [CNT_W-1:0] D_ALLRED     = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] D_GREEN_MIN  = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] D_YELLOW     = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] D_SIDE_GREEN = CNT_W'(T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] WALK_GAP     = CNT_W'(T_SIDE_GREEN - T_WALK);

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_ALLRED_1    = 3'd2;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] S_ALLRED_2    = 3'd5;
  localparam logic [2:0] S_FLASH       = 3'd6;

  logic [PRE_W-1:0] r_presc;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic             r_side_latch;
  logic             r_ped_latch;
  logic             r_flash_ph;
  logic             r_walk_active;
  logic [1:0]       r_R;
  logic [1:0]       r_Y;
  logic [1:0]       r_G;
  logic             r_W;

  logic             w_tick;
  logic             w_demand;
  logic             w_expire;
  logic             w_dec;
  logic [2:0]       w_nxt_state;
  logic [CNT_W-1:0] w_nxt_timer;
  logic             w_nxt_flash_ph;
  logic             w_enter_side;
  logic             w_nxt_walk;
  logic [1:0]       w_nxt_R;
  logic [1:0]       w_nxt_Y;
  logic [1:0]       w_nxt_G;
  logic             w_nxt_W;

  assign w_tick   = (r_presc == PRE_MAX);
  assign w_demand = r_side_latch | r_ped_latch;
  assign w_expire = w_tick && (r_timer == CNT_W'(1));
  assign w_dec    = w_tick && (r_timer > CNT_W'(1));

  // Prescaler, demand latches and walk capture
  always_ff @(posedge clk_27M) begin
    if (!reset) begin
      r_presc       <= '0;
      r_side_latch  <= 1'b0;
      r_ped_latch   <= 1'b0;
      r_walk_active <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PRE_W'(1);
      r_side_latch  <= w_enter_side ? 1'b0 : (r_side_latch | stopline);
      r_ped_latch   <= w_enter_side ? 1'b0 : (r_ped_latch | ped_req);
      r_walk_active <= w_nxt_walk;
    end
  end

  // State register with registered lamp outputs
  always_ff @(posedge clk_27M) begin
    if (!reset) begin
      r_state    <= S_ALLRED_2;
      r_timer    <= D_ALLRED;
      r_flash_ph <= 1'b0;
      r_R        <= 2'b11;
      r_Y        <= 2'b00;
      r_G        <= 2'b00;
      r_W        <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_timer    <= w_nxt_timer;
      r_flash_ph <= w_nxt_flash_ph;
      r_R        <= w_nxt_R;
      r_Y        <= w_nxt_Y;
      r_G        <= w_nxt_G;
      r_W        <= w_nxt_W;
    end
  end

  // Next state, phase timer and flash phase
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_timer    = r_timer;
    w_nxt_flash_ph = r_flash_ph;
    if (w_dec) begin
      w_nxt_timer = r_timer - CNT_W'(1);
    end
    if (flash_en) begin
      w_nxt_state = S_FLASH;
      if (r_state != S_FLASH) begin
        w_nxt_timer = '0;
      end else if (w_tick) begin
        w_nxt_flash_ph = ~r_flash_ph;
      end
    end else begin
      case (r_state)
        S_MAIN_GREEN: begin
          if (w_expire && w_demand) begin
            w_nxt_state = S_MAIN_YELLOW;
            w_nxt_timer = D_YELLOW;
          end
        end
        S_MAIN_YELLOW: begin
          if (w_expire) begin
            w_nxt_state = S_ALLRED_1;
            w_nxt_timer = D_ALLRED;
          end
        end
        S_ALLRED_1: begin
          if (w_expire) begin
            w_nxt_state = S_SIDE_GREEN;
            w_nxt_timer = D_SIDE_GREEN;
          end
        end
        S_SIDE_GREEN: begin
          if (w_expire) begin
            w_nxt_state = S_SIDE_YELLOW;
            w_nxt_timer = D_YELLOW;
          end
        end
        S_SIDE_YELLOW: begin
          if (w_expire) begin
            w_nxt_state = S_ALLRED_2;
            w_nxt_timer = D_ALLRED;
          end
        end
        S_ALLRED_2: begin
          if (w_expire) begin
            w_nxt_state = S_MAIN_GREEN;
            w_nxt_timer = D_GREEN_MIN;
          end
        end
        S_FLASH: begin
          if (w_tick) begin
            w_nxt_state = S_ALLRED_2;
            w_nxt_timer = D_ALLRED;
          end
        end
        default: begin
          w_nxt_state = S_ALLRED_2;
          w_nxt_timer = D_ALLRED;
        end
      endcase
    end
  end

  assign w_enter_side = (w_nxt_state == S_SIDE_GREEN) && (r_state != S_SIDE_GREEN);
  assign w_nxt_walk   = w_enter_side ? r_ped_latch : r_walk_active;

  // Lamp values for the upcoming state, registered alongside it
  always_comb begin
    w_nxt_R = 2'b11;
    w_nxt_Y = 2'b00;
    w_nxt_G = 2'b00;
    w_nxt_W = 1'b0;
    case (w_nxt_state)
      S_MAIN_GREEN: begin
        w_nxt_R = 2'b10;
        w_nxt_G = 2'b01;
      end
      S_MAIN_YELLOW: begin
        w_nxt_R = 2'b10;
        w_nxt_Y = 2'b01;
      end
      S_SIDE_GREEN: begin
        w_nxt_R = 2'b01;
        w_nxt_G = 2'b10;
        w_nxt_W = w_nxt_walk && (w_nxt_timer > WALK_GAP);
      end
      S_SIDE_YELLOW: begin
        w_nxt_R = 2'b01;
        w_nxt_Y = 2'b10;
      end
      S_FLASH: begin
        w_nxt_R = {w_nxt_flash_ph, 1'b0};
        w_nxt_Y = {1'b0, w_nxt_flash_ph};
      end
      default: begin
        w_nxt_R = 2'b11;
      end
    endcase
  end

  assign R         = r_R;
  assign Y         = r_Y;
  assign G         = r_G;
  assign W         = r_W;
  assign state     = r_state;
  assign countdown = r_timer;

endmodule

// File: tb/tb_traffic_light_actuated.sv
// Directed bench for traffic_light_actuated with a 4-cycle tick and short phases.
`timescale 1ns/1ps
module tb_traffic_light_actuated;

  logic       clk_27M = 1'b0;
  logic       reset = 1'b0;
  logic       stopline = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [1:0] R;
  logic [1:0] Y;
  logic [1:0] G;
  logic       W;
  logic [2:0] state;
  logic [7:0] countdown;

  int n_checks = 0;
  int n_err    = 0;

  traffic_light_actuated #(
    .TICK_DIV(4), .CNT_W(8), .T_ALLRED(1), .T_GREEN_MIN(3),
    .T_YELLOW(2), .T_SIDE_GREEN(4), .T_WALK(2)
  ) dut (
    .clk_27M(clk_27M), .reset(reset), .stopline(stopline), .ped_req(ped_req),
    .flash_en(flash_en), .R(R), .Y(Y), .G(G), .W(W), .state(state),
    .countdown(countdown)
  );

  always #5 clk_27M = ~clk_27M;

  task automatic cyc();
    @(posedge clk_27M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks {state,R,Y,G,W,countdown} for n samples; countdown starts at d, drops
  // every 4 cycles and rests at 1 (main green without demand).
  task automatic phase(input string tag, input logic [2:0] st, input int n,
                       input logic [1:0] r, input logic [1:0] y, input logic [1:0] g,
                       input logic w, input int d);
    logic [7:0] cd;
    for (int i = 0; i < n; i++) begin
      cd = (d > i / 4) ? 8'(d - i / 4) : 8'd1;
      chk($sformatf("%s[%0d]", tag, i), {14'd0, state, R, Y, G, W, countdown},
          {14'd0, st, r, y, g, w, cd});
      cyc();
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    for (int i = 0; i < budget && state != st; i++) cyc();
    chk(tag, 32'(state), 32'(st));
  endtask

  initial begin
    logic ph;
    // 1: reset, release, rest in main green
    cyc();
    cyc();
    chk("s1_rst_R", 32'(R), 32'h3);
    chk("s1_rst_YGW", {27'd0, Y, G, W}, 32'h0);
    reset = 1'b1;
    phase("s1_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    phase("s1_mg", 3'd0, 112, 2'b10, 2'b00, 2'b01, 1'b0, 3);

    // 2: one-cycle stopline pulse drives a full side service
    stopline = 1'b1;
    cyc();
    stopline = 1'b0;
    chk("s2_side_latch", 32'(dut.r_side_latch), 32'd1);
    phase("s2_mg", 3'd0, 3, 2'b10, 2'b00, 2'b01, 1'b0, 1);
    phase("s2_my", 3'd1, 8, 2'b10, 2'b01, 2'b00, 1'b0, 2);
    phase("s2_ar1", 3'd2, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    chk("s2_side_clr", 32'(dut.r_side_latch), 32'd0);
    phase("s2_sg", 3'd3, 16, 2'b01, 2'b00, 2'b10, 1'b0, 4);
    phase("s2_sy", 3'd4, 8, 2'b01, 2'b10, 2'b00, 1'b0, 2);
    phase("s2_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    chk("s2_back_mg", {state, countdown}, {3'd0, 8'd3});

    // 3: pedestrian pulse gives walk for the first two side-green ticks
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_state("s3_wait_my", 3'd1, 40);
    phase("s3_my", 3'd1, 8, 2'b10, 2'b01, 2'b00, 1'b0, 2);
    phase("s3_ar1", 3'd2, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    chk("s3_ped_clr", 32'(dut.r_ped_latch), 32'd0);
    phase("s3_sg_walk", 3'd3, 8, 2'b01, 2'b00, 2'b10, 1'b1, 4);
    phase("s3_sg_nowalk", 3'd3, 8, 2'b01, 2'b00, 2'b10, 1'b0, 2);
    phase("s3_sy", 3'd4, 8, 2'b01, 2'b10, 2'b00, 1'b0, 2);
    phase("s3_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);

    // 4: stopline held; service repeats with 12-cycle main greens
    stopline = 1'b1;
    for (int k = 0; k < 2; k++) begin
      phase("s4_mg", 3'd0, 12, 2'b10, 2'b00, 2'b01, 1'b0, 3);
      phase("s4_my", 3'd1, 8, 2'b10, 2'b01, 2'b00, 1'b0, 2);
      phase("s4_ar1", 3'd2, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
      phase("s4_sg", 3'd3, 16, 2'b01, 2'b00, 2'b10, 1'b0, 4);
      phase("s4_sy", 3'd4, 8, 2'b01, 2'b10, 2'b00, 1'b0, 2);
      phase("s4_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    end
    phase("s4_mg3", 3'd0, 12, 2'b10, 2'b00, 2'b01, 1'b0, 3);
    phase("s4_my3", 3'd1, 8, 2'b10, 2'b01, 2'b00, 1'b0, 2);
    phase("s4_ar13", 3'd2, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    stopline = 1'b0;
    phase("s4_sg3", 3'd3, 5, 2'b01, 2'b00, 2'b10, 1'b0, 4);

    // 5: flash mid side green; phase toggles on ticks, latch still accumulates
    flash_en = 1'b1;
    cyc();
    for (int k = 6; k < 24; k++) begin
      ph = 1'((k / 4 + 1) % 2);
      if (k == 10) stopline = 1'b1;
      if (k == 11) stopline = 1'b0;
      if (k == 20) begin
        chk("s5_latch_acc", 32'(dut.r_side_latch), 32'd1);
        flash_en = 1'b0;
      end
      chk($sformatf("s5_flash[%0d]", k), {14'd0, state, R, Y, G, W, countdown},
          {14'd0, 3'd6, ph, 1'b0, 1'b0, ph, 2'b00, 1'b0, 8'd0});
      cyc();
    end
    phase("s5_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    phase("s5_mg", 3'd0, 12, 2'b10, 2'b00, 2'b01, 1'b0, 3);

    // 6: reset in main yellow restarts the sequence
    chk("s6_in_my", 32'(state), 32'd1);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("s6_rst_out", {14'd0, state, R, Y, G, W, countdown},
        {14'd0, 3'd5, 2'b11, 2'b00, 2'b00, 1'b0, 8'd1});
    chk("s6_rst_latch", {30'd0, dut.r_side_latch, dut.r_ped_latch}, 32'd0);
    chk("s6_rst_presc", 32'(dut.r_presc), 32'd0);
    reset = 1'b1;
    phase("s6_ar2", 3'd5, 4, 2'b11, 2'b00, 2'b00, 1'b0, 1);
    phase("s6_mg", 3'd0, 32, 2'b10, 2'b00, 2'b01, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_light_actuated.md
Name: traffic_light_actuated

Overview:
- Parametrised successor to the single-approach traffic_light controller.
- Drives a two-approach intersection: main road (index 0) and side road (index 1). Adds vehicle-actuated side phase via stopline, a latched pedestrian walk request, a flashing night/fault mode, and configurable tick prescaling and phase durations.
- Sits directly behind the board's 27 MHz clock; outputs drive lamp LEDs.

Parameters:
- TICK_DIV, 27000000: clk_27M cycles per timing tick (1 s at 27 MHz). Bench overrides it small.
- CNT_W, 8: width of the phase timer and countdown output.
- T_ALLRED, 1: all-red clearance, in ticks.
- T_GREEN_MIN, 10: minimum main green, in ticks.
- T_YELLOW, 3: yellow duration, in ticks (both approaches).
- T_SIDE_GREEN, 8: side green duration, in ticks.
- T_WALK, 5: walk duration at start of side green, in ticks. Must be ≤ T_SIDE_GREEN.

Ports:
- clk_27M  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- stopline  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button (cross main road), level/pulse
- flash_en  in  1  flashing-mode request, level
- R  out  2  red lamps, [0]=main, [1]=side
- Y  out  2  yellow lamps
- G  out  2  green lamps
- W  out  1  walk lamp (pedestrian crossing main road)
- state  out  3  current state encoding
- countdown  out  CNT_W  ticks remaining in current phase; 0 in FLASH

Behaviour:
- Reset (reset==0 at a clk_27M edge):
  - State goes to ALLRED_2 (encoding 5) with timer = T_ALLRED.
  - Prescaler = 0, both request latches = 0, flash phase = 0.
  - Outputs: R=2'b11, Y=0, G=0, W=0, countdown=T_ALLRED.
  - Applies mid-phase and overrides every other input.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when the count is TICK_DIV-1.
  - Cleared only by reset.
  - First tick occurs TICK_DIV cycles after reset deasserts.
- State encodings: MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALLRED_2=5, FLASH=6. Encoding 7 is illegal; it recovers to ALLRED_2 on the next edge.
- Timer:
  - Loaded with the phase duration D on state entry.
  - On each tick: if timer==1 and the exit condition holds, transition; else if timer>1, decrement.
  - Timed phases therefore last exactly D ticks.
- Transitions (on tick only, except FLASH entry):
  - ALLRED_2 → MAIN_GREEN (load T_GREEN_MIN).
  - MAIN_GREEN: once timer==1, stays at 1 until demand = (side_latch | ped_latch) is set, then goes to MAIN_YELLOW on a tick. Main rests in green indefinitely with no demand.
  - MAIN_YELLOW → ALLRED_1 → SIDE_GREEN.
  - SIDE_GREEN → SIDE_YELLOW → ALLRED_2.
- Lamps per state:
  - Main G in MAIN_GREEN, Y in MAIN_YELLOW, R otherwise.
  - Side G in SIDE_GREEN, Y in SIDE_YELLOW, R otherwise.
  - Exactly one of R/Y/G is high per approach outside FLASH.
  - G[0] and G[1] are never high together.
- Request latches:
  - side_latch is set by stopline==1; ped_latch is set by ped_req==1.
  - Both are cleared on the SIDE_GREEN entry edge. Clear wins over a same-cycle set.
  - An input still held high re-sets its latch on the next cycle, so it is served next cycle.
- Walk:
  - W=1 during the first T_WALK ticks of SIDE_GREEN, only if ped_latch was 1 on entry (captured into walk_active).
  - W=0 in all other states and on reset.
- Flash:
  - flash_en==1 forces FLASH on the next edge from any state, without waiting for a tick.
  - In FLASH: R[0]=0, G=0, W=0, Y[0]=flash phase, R[1]=flash phase, Y[1]=0. Flash phase toggles each tick.
  - Latches keep accumulating during FLASH.
  - flash_en==0 in FLASH: go to ALLRED_2 on the next tick, loading T_ALLRED.
- Timing: all outputs are registered and change on the same edge as state; no combinational input-to-output path.
- Widths: all durations must be 1..2^CNT_W-1. A duration of 0 is illegal and is not handled.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, T_ALLRED=1, T_GREEN_MIN=3, T_YELLOW=2, T_SIDE_GREEN=4, T_WALK=2.
1. Reset, then release with no requests:
   - R=11 for 4 cycles, then state=0, G=01, R=10.
   - Stays in MAIN_GREEN with countdown=1 for 100 cycles.
2. stopline pulsed 1 cycle during MAIN_GREEN:
   - Sequence MAIN_YELLOW (8 cycles), ALLRED_1 (4 cycles), SIDE_GREEN (16 cycles, G=10, W=0), SIDE_YELLOW (8 cycles), ALLRED_2 (4 cycles), MAIN_GREEN.
3. ped_req pulse:
   - In SIDE_GREEN, W=1 for exactly 8 cycles, then 0.
   - ped_latch reads 0 after SIDE_GREEN entry.
4. stopline held high continuously:
   - Side phase repeats each cycle.
   - Main green lasts exactly 12 cycles between services.
   - G never equals 11.
5. flash_en raised mid SIDE_GREEN:
   - Next edge: state=6, G=0, W=0, Y[0] and R[1] toggle every 4 cycles.
   - Dropping flash_en gives ALLRED_2 at the next tick, then MAIN_GREEN.
6. reset asserted mid MAIN_YELLOW:
   - Next edge: state=5, R=11, Y=0, countdown=1, latches cleared.
   - Sequence restarts as in scenario 1.
